// File: rtl/bist_sum_total.sv
// Self-test sweeper for the sumTotal full adder: drives all eight input vectors,
// checks both adder implementations against the full-adder truth table and reports the results.
module bist_sum_total #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       in_a,
  output logic       in_b,
  output logic       cin,
  input  logic       sumPuertas,
  input  logic       coutPuertas,
  input  logic       sumComp,
  input  logic       coutComp,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_err_vec,
  output logic       first_err_valid
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] err_q, err_d;
  logic [2:0] ferr_q, ferr_d;
  logic       fval_q, fval_d;

  logic exp_sum, exp_cout, vec_fail, launch;

  assign exp_sum  = ^vec_q;
  assign exp_cout = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
  // Any number of mismatching outputs on one vector counts as a single failure.
  assign vec_fail = (sumPuertas != exp_sum) | (sumComp != exp_sum) |
                    (coutPuertas != exp_cout) | (coutComp != exp_cout);
  assign launch   = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= 3'd0;
      cnt_q   <= 4'd0;
      err_q   <= 4'd0;
      ferr_q  <= 3'd0;
      fval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      fval_q  <= fval_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    fval_d  = fval_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (launch) begin
          state_d = S_WAIT;
          vec_d   = 3'd0;
          cnt_d   = RELOAD;
          err_d   = 4'd0;
          ferr_d  = 3'd0;
          fval_d  = 1'b0;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_CHECK: begin
        if (vec_fail) begin
          err_d = err_q + 4'd1;
          if (!fval_q) begin
            ferr_d = vec_q;
            fval_d = 1'b1;
          end
        end
        if (vec_q == 3'd7) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          vec_d   = vec_q + 3'd1;
          cnt_d   = RELOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_WAIT) || (state_q == S_CHECK);
    done = (state_q == S_DONE);
    pass = (state_q == S_DONE) && (err_q == 4'd0);
  end

  assign {in_a, in_b, cin} = vec_q;
  assign err_count         = err_q;
  assign first_err_vec     = ferr_q;
  assign first_err_valid   = fval_q;

endmodule

// File: tb/tb_bist_sum_total.sv
// Bench for bist_sum_total: a fault-injectable adder model feeds two DUTs (SETTLE=1 and SETTLE=3),
// and every cycle of each sweep is compared against an arithmetic reference of the expected result.
module tb_bist_sum_total;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-vector output flips applied to the adder model (bit v set = that output wrong for vector v).
  logic [7:0] flip_sp = 8'h00, flip_sc = 8'h00, flip_cp = 8'h00, flip_cc = 8'h00;

  logic       start1 = 1'b0, start3 = 1'b0;
  logic       a1, b1, c1, a3, b3, c3;
  logic       sp1, cp1, sc1, cc1, sp3, cp3, sc3, cc3;
  logic       busy1, done1, pass1, fv1, busy3, done3, pass3, fv3;
  logic [3:0] err1, err3;
  logic [2:0] fe1, fe3;

  function automatic logic [1:0] adder(input logic [2:0] v);
    int s;
    s = int'(v[2]) + int'(v[1]) + int'(v[0]);
    return {logic'(s >= 2), logic'(s % 2)};  // {cout, sum}
  endfunction

  always_comb begin
    logic [2:0] v;
    logic [1:0] g;
    v = {a1, b1, c1};
    g = adder(v);
    sp1 = g[0] ^ flip_sp[v];
    sc1 = g[0] ^ flip_sc[v];
    cp1 = g[1] ^ flip_cp[v];
    cc1 = g[1] ^ flip_cc[v];
  end

  always_comb begin
    logic [2:0] v;
    logic [1:0] g;
    v = {a3, b3, c3};
    g = adder(v);
    sp3 = g[0] ^ flip_sp[v];
    sc3 = g[0] ^ flip_sc[v];
    cp3 = g[1] ^ flip_cp[v];
    cc3 = g[1] ^ flip_cc[v];
  end

  bist_sum_total #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .in_a(a1), .in_b(b1), .cin(c1),
    .sumPuertas(sp1), .coutPuertas(cp1), .sumComp(sc1), .coutComp(cc1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_err_vec(fe1), .first_err_valid(fv1)
  );

  bist_sum_total #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .in_a(a3), .in_b(b3), .cin(c3),
    .sumPuertas(sp3), .coutPuertas(cp3), .sumComp(sc3), .coutComp(cc3),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_err_vec(fe3), .first_err_valid(fv3)
  );

  // Runs one sweep on the selected DUT and checks every cycle against the reference.
  task automatic run_sweep(input string name, input bit sel3, input bit poke);
    int per, total, checked, exp_err, exp_first, exp_vec;
    logic o_busy, o_done, o_pass, o_fv;
    logic [3:0] o_err;
    logic [2:0] o_fe, o_vec;
    logic [7:0] fails;
    per   = sel3 ? 4 : 2;
    total = 8 * per;
    fails = flip_sp | flip_sc | flip_cp | flip_cc;
    @(negedge clk);
    if (sel3) start3 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
    for (int n = 0; n <= total; n++) begin
      checked   = (n / per > 8) ? 8 : n / per;
      exp_vec   = (n < total) ? n / per : 7;
      exp_err   = 0;
      exp_first = -1;
      for (int k = 0; k < checked; k++) begin
        if (fails[k]) begin
          exp_err++;
          if (exp_first < 0) exp_first = k;
        end
      end
      if (sel3) begin
        o_busy = busy3; o_done = done3; o_pass = pass3; o_fv = fv3;
        o_err = err3; o_fe = fe3; o_vec = {a3, b3, c3};
      end else begin
        o_busy = busy1; o_done = done1; o_pass = pass1; o_fv = fv1;
        o_err = err1; o_fe = fe1; o_vec = {a1, b1, c1};
      end
      checks += 7;
      if (o_busy !== logic'(n < total)) begin
        errors++; $display("FAIL %s busy cyc=%0d got=%b exp=%b", name, n, o_busy, n < total);
      end
      if (o_done !== logic'(n == total)) begin
        errors++; $display("FAIL %s done cyc=%0d got=%b exp=%b", name, n, o_done, n == total);
      end
      if (o_pass !== logic'(n == total && exp_err == 0)) begin
        errors++; $display("FAIL %s pass cyc=%0d got=%b exp=%b", name, n, o_pass, n == total && exp_err == 0);
      end
      if (o_vec !== 3'(exp_vec)) begin
        errors++; $display("FAIL %s stimulus cyc=%0d got=%0d exp=%0d", name, n, o_vec, exp_vec);
      end
      if (o_err !== 4'(exp_err)) begin
        errors++; $display("FAIL %s err_count cyc=%0d got=%0d exp=%0d", name, n, o_err, exp_err);
      end
      if (o_fv !== logic'(exp_first >= 0)) begin
        errors++; $display("FAIL %s first_err_valid cyc=%0d got=%b exp=%b", name, n, o_fv, exp_first >= 0);
      end
      if (o_fe !== 3'((exp_first >= 0) ? exp_first : 0)) begin
        errors++; $display("FAIL %s first_err_vec cyc=%0d got=%0d exp=%0d", name, n, o_fe, (exp_first >= 0) ? exp_first : 0);
      end
      if (n == total) break;
      if (poke && (n == 5 || n == 11)) begin
        if (sel3) start3 = 1'b1; else start1 = 1'b1;
      end else begin
        start1 = 1'b0;
        start3 = 1'b0;
      end
      @(negedge clk);
    end
    start1 = 1'b0;
    start3 = 1'b0;
    $display("sweep %s: err_count=%0d first_err_vec=%0d valid=%b pass=%b",
             name, sel3 ? err3 : err1, sel3 ? fe3 : fe1, sel3 ? fv3 : fv1, sel3 ? pass3 : pass1);
  endtask

  task automatic check_all_zero(input string name);
    logic [14:0] obs;
    obs = {a1, b1, c1, busy1, done1, pass1, err1, fe1, fv1};
    checks++;
    if (obs !== 15'd0) begin
      errors++; $display("FAIL %s outputs got=%h exp=0", name, obs);
    end
    obs = {a3, b3, c3, busy3, done3, pass3, err3, fe3, fv3};
    checks++;
    if (obs !== 15'd0) begin
      errors++; $display("FAIL %s outputs(settle3) got=%h exp=0", name, obs);
    end
    $display("reset check %s", name);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_good_adder;
    flip_sp = 0; flip_sc = 0; flip_cp = 0; flip_cc = 0;
    run_sweep("good", 1'b0, 1'b0);
  endtask

  task automatic test_sumcomp_stuck0;
    flip_sp = 0; flip_cp = 0; flip_cc = 0;
    for (int v = 0; v < 8; v++) flip_sc[v] = adder(3'(v)) & 2'b01 ? 1'b1 : 1'b0;
    run_sweep("sumComp_stuck0", 1'b0, 1'b0);
  endtask

  task automatic test_coutp_inverted;
    flip_sp = 0; flip_sc = 0; flip_cc = 0; flip_cp = 8'hFF;
    run_sweep("coutPuertas_inv", 1'b0, 1'b0);
  endtask

  task automatic test_random_faults;
    for (int i = 0; i < 6; i++) begin
      flip_sp = 8'($urandom) & 8'($urandom);
      flip_sc = 8'($urandom) & 8'($urandom);
      flip_cp = 8'($urandom) & 8'($urandom);
      flip_cc = 8'($urandom) & 8'($urandom);
      run_sweep($sformatf("random%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_mid_sweep_start;
    flip_sp = 8'h21; flip_sc = 0; flip_cp = 0; flip_cc = 8'h04;
    run_sweep("start_ignored", 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back;
    flip_sp = 8'h80; flip_sc = 0; flip_cp = 0; flip_cc = 0;
    run_sweep("b2b_first", 1'b0, 1'b0);
    flip_sp = 0;
    run_sweep("b2b_restart", 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_sweep;
    flip_sp = 8'h05; flip_sc = 0; flip_cp = 0; flip_cc = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (7) @(negedge clk);  // vector 3 is on the bus now
    checks++;
    if ({a1, b1, c1} !== 3'd3) begin
      errors++; $display("FAIL mid_reset vec_before got=%0d exp=3", {a1, b1, c1});
    end
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_mid_sweep");
    @(negedge clk);
    rst_n = 1'b1;
    flip_sp = 0; flip_cc = 8'h40;
    run_sweep("after_reset", 1'b0, 1'b0);
  endtask

  task automatic test_settle3;
    flip_sp = 0; flip_sc = 0; flip_cp = 0; flip_cc = 0;
    run_sweep("settle3_good", 1'b1, 1'b0);
    flip_cp = 8'h18;
    run_sweep("settle3_fault", 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_good_adder();
    test_sumcomp_stuck0();
    test_coutp_inverted();
    test_mid_sweep_start();
    test_back_to_back();
    test_reset_mid_sweep();
    test_settle3();
    test_random_faults();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bist_sum_total.md
# bist_sum_total

Synthesizable built-in self-test controller for the `sumTotal` full adder. It sits on the opposite side of the adder's port list: it drives `in_a`, `in_b` and `cin`, and samples all four adder outputs. On `start` it sweeps the eight input combinations and compares both implementations against the golden full-adder function. It then reports pass/fail, a mismatch count and the first failing vector, so the adder can be checked on silicon or FPGA without a simulator.

## Interface
Parameters:
- `SETTLE`, default 1: cycles each vector is held before sampling. Legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  begin a sweep; sampled only in IDLE or DONE.
- `in_a`, `in_b`, `cin`  out  1 each  registered stimulus to the adder.
- `sumPuertas`, `coutPuertas`  in  1 each  gate-level adder outputs.
- `sumComp`, `coutComp`  in  1 each  behavioural adder outputs.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  high in DONE; held until the next `start`.
- `pass`  out  1  high in DONE only when `err_count` == 0.
- `err_count`  out  4  number of failing vectors, 0..8.
- `first_err_vec`  out  3  the {in_a,in_b,cin} value of the first failing vector.
- `first_err_valid`  out  1  `first_err_vec` holds a captured value.

## Operation
- Internal 3-bit vector register `vec`; stimulus outputs are `{in_a,in_b,cin} = vec`.
- Expected values for each vector:
  - exp_sum = in_a ^ in_b ^ cin
  - exp_cout = majority(in_a,in_b,cin)
- A vector fails if any of `sumPuertas`, `sumComp` differs from exp_sum, or any of `coutPuertas`, `coutComp` differs from exp_cout.
- A failing vector counts once, however many outputs mismatch.
- FSM states: IDLE, WAIT, CHECK, DONE.
  - IDLE: `start`=1 → WAIT. Load `vec`=0 and wait counter=SETTLE-1. Clear `err_count`, `first_err_vec` and `first_err_valid`.
  - WAIT: decrement the counter. When counter==0 → CHECK.
  - CHECK: compare the adder outputs sampled at this edge.
    - On failure: `err_count` += 1.
    - On failure with `first_err_valid`=0: capture `vec` into `first_err_vec` and set `first_err_valid`.
    - If `vec`==7 → DONE; otherwise `vec` += 1, reload the counter, → WAIT.
  - DONE: `done`=1; `pass` = (`err_count`==0).
    - `start`=1 → restart exactly as from IDLE. Clear `done`/`pass` on the same edge.
- `busy` = (state is WAIT or CHECK).
- `start` is ignored in WAIT and CHECK.
- `err_count` cannot exceed 8 by construction; no wrap is possible.
- `vec` is not incremented past 7; it holds 7 in DONE.
- Adder outputs are sampled directly, with no synchronizer: the adder is combinational in the same clock domain.

## Timing
- Reset (`rst_n`=0, any time, asynchronous):
  - state = IDLE.
  - `in_a`/`in_b`/`cin`, `busy`, `done`, `pass`, `err_count`, `first_err_vec` and `first_err_valid` are all 0.
- Reset mid-sweep aborts the sweep with no partial result. The next `start` runs from `vec`=0.
- Edge E0 samples `start`=1:
  - From E0: `busy`=1 and stimulus = 000.
  - Each vector is held for SETTLE+1 cycles: SETTLE in WAIT, 1 in CHECK.
  - The check for vector k happens at edge E0 + (k+1)(SETTLE+1).
  - `done` rises at E0 + 8(SETTLE+1), i.e. 16 cycles for SETTLE=1. `busy` falls on the same edge.
- `err_count` and `first_err_*` update at the CHECK edge of each failing vector. They are visible in the following cycle.
- Stimulus changes only at the CHECK→WAIT edge. Every vector is stable for SETTLE+1 cycles before its sample edge.

## Test plan
- Correct adder model, SETTLE=1, pulse `start` → `busy` for 16 cycles, then `done`=1, `pass`=1, `err_count`=0, `first_err_valid`=0.
- `sumComp` stuck at 0 → failures on vectors 1,2,4,7: `err_count`=4, `first_err_vec`=3'b001, `pass`=0.
- `coutPuertas` inverted → all 8 vectors fail: `err_count`=8, `first_err_vec`=3'b000.
- Assert `rst_n`=0 during vector 3 → all outputs 0 immediately, including before the next clock edge. A later `start` drives 000 first and completes with fresh results.
- Pulse `start` mid-sweep → no effect and completion time unchanged. `start` in DONE → `done` clears and the sweep repeats with cleared counters.
- SETTLE=3, correct model → `done` 32 cycles after `start`. Each stimulus value is held 4 cycles.
